sincronizador: RTL and testbench
================================

# sincronizador

Code-group synchronizer for the 1000BASE-X PCS receive path. Takes the aligned 10-bit code-group stream (PUDI) from the deserializer and runs the clause-36 synchronization state machine. Tags each code group with its even/odd position and produces SUDI and SYNC_STATUS, which drive the receptor directly.

## Interface
Parameters:
- GOOD_CGS_LIMIT, 3: consecutive good code groups needed to step back one SYNC_ACQUIRED level.

Ports:
- CLK  input  1  receive clock; one code group per rising edge.
- RESET  input  1  synchronous, active-high reset.
- PUDI  input  10  aligned code group, bit order {abcdei, fghj}, PUDI[9] = a.
- SUDI  output  11  {code group[9:0], rx_even}; SUDI[0]=1 marks the even position.
- SYNC_STATUS  output  1  1 = sync OK.

## Operation
- comma = PUDI equal to K28.5+ (10'b1100000101) or K28.5− (10'b0011111010).
- cgbad:
  - a comma arriving while the current rx_even = 1, so it would fall on an odd slot; or
  - a balance-check failure (see Configuration).
- cggood = !cgbad.
- The FSM consumes one PUDI per cycle. rx_even is set by the state entered:
  - COMMA_DETECT_n: rx_even = 1.
  - All other states: rx_even toggles.
- States and transitions:
  - LOSS_OF_SYNC: comma → COMMA_DETECT_1; else stay.
  - COMMA_DETECT_n (n = 1..3): non-comma cggood → ACQUIRE_SYNC_n (n = 1, 2) or SYNC_ACQUIRED_1 (n = 3); else → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_n (n = 1, 2): cgbad → LOSS_OF_SYNC; comma → COMMA_DETECT_{n+1}; else stay.
  - SYNC_ACQUIRED_1: cgbad → SYNC_ACQUIRED_2; else stay.
  - SYNC_ACQUIRED_n (n = 2..4): clear good_cgs. cggood → nA (good_cgs = 1). cgbad → n+1, or LOSS_OF_SYNC when n = 4.
  - nA: cgbad → n+1, or LOSS_OF_SYNC when n = 4. cggood increments good_cgs; reaching GOOD_CGS_LIMIT → SYNC_ACQUIRED_{n−1}, else stay.
- SYNC_STATUS = 1 in every SYNC_ACQUIRED_* and nA state, 0 otherwise.
- good_cgs: 2-bit saturating counter, cleared on entry to SYNC_ACQUIRED_2/3/4.
- PUDI passes through unmodified. Code groups are never dropped or substituted, including during loss of sync.

## Timing
- Latency: exactly 1 cycle. The PUDI sampled at edge k appears at edge k as SUDI[10:1], together with the rx_even and SYNC_STATUS of the state entered at edge k.
- Example: the third comma/D5.6 pair raises SYNC_STATUS on the same cycle SUDI carries that D5.6.
- Reset values: state = LOSS_OF_SYNC, SUDI = 11'd0, SYNC_STATUS = 0, rx_even = 0, good_cgs = 0.
- RESET overrides all inputs.
- Reset mid-stream: outputs reach reset values on the next edge, and synchronization restarts from LOSS_OF_SYNC.
- A comma plus balance failure in the same group counts as cgbad, not as a comma.
- A cgbad in an nA state takes priority over the good_cgs count.

## Configuration
- SINC_BALANCE_CHECK_EN defined: cgbad also covers structural imbalance, i.e. any of:
  - ones(PUDI) not in 4..6;
  - ones(abcdei) not in 2..4;
  - ones(fghj) not in 1..3.
- SINC_BALANCE_CHECK_EN undefined: cgbad is only a misaligned comma. The balance logic is not synthesized.

## Structure
- Shared package sincronizador_pkg holds:
  - K28_5_P and K28_5_N constants;
  - 4-bit state encodings for all 13 states;
  - the SUDI field positions.
- One combinational sub-module, detector_cg: PUDI and current rx_even in, comma and cgbad out. It holds the SINC_BALANCE_CHECK_EN logic.
- The FSM, good_cgs counter and output registers live in sincronizador.

## Test plan
- Reset: RESET = 1 for 2 cycles with random PUDI → SUDI = 0, SYNC_STATUS = 0 throughout.
- Acquisition: three K28.5+/D5.6 pairs (1100000101, 1010010110) → commas output with SUDI[0] = 1, D5.6 with 0. SYNC_STATUS rises with the 3rd D5.6 (SUDI = 11'b10100101100).
- Misaligned comma: comma, D5.6, D5.6, comma → the last comma is cgbad, FSM returns to LOSS_OF_SYNC, SYNC_STATUS stays 0.
- Loss: after sync, four groups of 10'b1111111111 (EN defined) → SYNC_STATUS falls on the 4th bad output.
- Recovery: after sync, bad, then 3 good → back in SYNC_ACQUIRED_1, SYNC_STATUS stays 1. Alternating bad/good ×3 then bad → SYNC_STATUS falls on the 4th bad.
- Mid-stream reset: RESET pulsed during a data burst (K27.7 then data) → SUDI = 0, SYNC_STATUS = 0 next cycle; re-acquisition needs three fresh comma pairs.

Source files
------------

// File: rtl/sincronizador_pkg.sv
// Shared constants, state encodings and SUDI field layout for the code-group synchronizer.
// Latency: n/a (declarations only). Backpressure: n/a.
package sincronizador_pkg;

  localparam logic [9:0] K28_5_P = 10'b1100000101;
  localparam logic [9:0] K28_5_N = 10'b0011111010;

  localparam int SUDI_W        = 11;
  localparam int SUDI_EVEN_BIT = 0;
  localparam int SUDI_CG_LSB   = 1;
  localparam int SUDI_CG_MSB   = 10;

  typedef enum logic [3:0] {
    ST_LOSS_OF_SYNC     = 4'd0,
    ST_COMMA_DETECT_1   = 4'd1,
    ST_ACQUIRE_SYNC_1   = 4'd2,
    ST_COMMA_DETECT_2   = 4'd3,
    ST_ACQUIRE_SYNC_2   = 4'd4,
    ST_COMMA_DETECT_3   = 4'd5,
    ST_SYNC_ACQUIRED_1  = 4'd6,
    ST_SYNC_ACQUIRED_2  = 4'd7,
    ST_SYNC_ACQUIRED_2A = 4'd8,
    ST_SYNC_ACQUIRED_3  = 4'd9,
    ST_SYNC_ACQUIRED_3A = 4'd10,
    ST_SYNC_ACQUIRED_4  = 4'd11,
    ST_SYNC_ACQUIRED_4A = 4'd12
  } sync_state_t;

  function automatic logic [3:0] count_ones(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sincronizador_if.sv
// Code-group bundle between deserializer, synchronizer and receptor.
// Latency: n/a (wiring only). Backpressure: none, one code group per clock.
interface sincronizador_if;
  import sincronizador_pkg::*;

  logic [9:0]        PUDI;
  logic [SUDI_W-1:0] SUDI;
  logic              SYNC_STATUS;

  modport master (output PUDI, input SUDI, input SYNC_STATUS);
  modport slave  (input PUDI, output SUDI, output SYNC_STATUS);
endinterface

// File: rtl/detector_cg.sv
// Classifies one code group as comma and/or cgbad; SINC_BALANCE_CHECK_EN adds disparity-structure checks.
// Latency: combinational. Backpressure: none.
module detector_cg
  import sincronizador_pkg::*;
(
  input  logic [9:0] pudi,
  input  logic       rx_even,
  output logic       comma,
  output logic       cgbad
);

  logic is_k28_5;
  logic imbalance;

  assign is_k28_5 = (pudi == K28_5_P) || (pudi == K28_5_N);

`ifdef SINC_BALANCE_CHECK_EN
  logic [3:0] n_all;
  logic [3:0] n_hi;
  logic [3:0] n_lo;

  assign n_all = count_ones(pudi);
  assign n_hi  = count_ones({4'd0, pudi[9:4]});
  assign n_lo  = count_ones({6'd0, pudi[3:0]});

  assign imbalance = (n_all < 4'd4) || (n_all > 4'd6) ||
                     (n_hi  < 4'd2) || (n_hi  > 4'd4) ||
                     (n_lo  < 4'd1) || (n_lo  > 4'd3);
`else
  assign imbalance = 1'b0;
`endif

  // An unbalanced group is never treated as a comma, only as bad.
  assign comma = is_k28_5 && !imbalance;
  assign cgbad = (comma && rx_even) || imbalance;

endmodule

// File: rtl/sincronizador.sv
// 1000BASE-X receive synchronization FSM: tags code groups with rx_even and drives SYNC_STATUS (SINC_BALANCE_CHECK_EN enables balance checks).
// Latency: 1 cycle, PUDI at edge k appears on SUDI at edge k. Backpressure: none, every code group passes through.
module sincronizador
  import sincronizador_pkg::*;
#(
  parameter int GOOD_CGS_LIMIT = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  sincronizador_if.slave sif
);

  sync_state_t       state;
  sync_state_t       next_state;
  logic [1:0]        good_cgs;
  logic [1:0]        next_good_cgs;
  logic [SUDI_W-1:0] sudi_q;
  logic [SUDI_W-1:0] sudi_d;
  logic              sync_q;
  logic              next_sync;
  logic              next_rx_even;
  logic              rx_even;
  logic              comma;
  logic              cgbad;
  logic              good_limit;

  // rx_even of the current state is the tag already on SUDI.
  assign rx_even = sudi_q[SUDI_EVEN_BIT];

  detector_cg u_detector_cg (
    .pudi    (sif.PUDI),
    .rx_even (rx_even),
    .comma   (comma),
    .cgbad   (cgbad)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_LOSS_OF_SYNC;
      good_cgs <= 2'd0;
    end else begin
      state    <= next_state;
      good_cgs <= next_good_cgs;
    end
  end

  assign good_limit = (int'(good_cgs) + 1) >= GOOD_CGS_LIMIT;

  always_comb begin
    next_state    = state;
    next_good_cgs = good_cgs;
    case (state)
      ST_LOSS_OF_SYNC:
        if (comma) next_state = ST_COMMA_DETECT_1;
      ST_COMMA_DETECT_1:
        next_state = (!comma && !cgbad) ? ST_ACQUIRE_SYNC_1 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_2:
        next_state = (!comma && !cgbad) ? ST_ACQUIRE_SYNC_2 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_3:
        next_state = (!comma && !cgbad) ? ST_SYNC_ACQUIRED_1 : ST_LOSS_OF_SYNC;
      ST_ACQUIRE_SYNC_1:
        if (cgbad)      next_state = ST_LOSS_OF_SYNC;
        else if (comma) next_state = ST_COMMA_DETECT_2;
      ST_ACQUIRE_SYNC_2:
        if (cgbad)      next_state = ST_LOSS_OF_SYNC;
        else if (comma) next_state = ST_COMMA_DETECT_3;
      ST_SYNC_ACQUIRED_1:
        if (cgbad) next_state = ST_SYNC_ACQUIRED_2;
      ST_SYNC_ACQUIRED_2:
        next_state = cgbad ? ST_SYNC_ACQUIRED_3 : ST_SYNC_ACQUIRED_2A;
      ST_SYNC_ACQUIRED_3:
        next_state = cgbad ? ST_SYNC_ACQUIRED_4 : ST_SYNC_ACQUIRED_3A;
      ST_SYNC_ACQUIRED_4:
        next_state = cgbad ? ST_LOSS_OF_SYNC : ST_SYNC_ACQUIRED_4A;
      ST_SYNC_ACQUIRED_2A:
        if (cgbad)           next_state = ST_SYNC_ACQUIRED_3;
        else if (good_limit) next_state = ST_SYNC_ACQUIRED_1;
      ST_SYNC_ACQUIRED_3A:
        if (cgbad)           next_state = ST_SYNC_ACQUIRED_4;
        else if (good_limit) next_state = ST_SYNC_ACQUIRED_2;
      ST_SYNC_ACQUIRED_4A:
        if (cgbad)           next_state = ST_LOSS_OF_SYNC;
        else if (good_limit) next_state = ST_SYNC_ACQUIRED_3;
      default:
        next_state = ST_LOSS_OF_SYNC;
    endcase

    case (state)
      ST_SYNC_ACQUIRED_2, ST_SYNC_ACQUIRED_3, ST_SYNC_ACQUIRED_4:
        if (!cgbad) next_good_cgs = 2'd1;
      ST_SYNC_ACQUIRED_2A, ST_SYNC_ACQUIRED_3A, ST_SYNC_ACQUIRED_4A:
        if (!cgbad) next_good_cgs = (good_cgs == 2'd3) ? 2'd3 : good_cgs + 2'd1;
      default: ;
    endcase

    // Counter restarts whenever a SYNC_ACQUIRED_2/3/4 level is entered.
    if (next_state == ST_SYNC_ACQUIRED_2 || next_state == ST_SYNC_ACQUIRED_3 ||
        next_state == ST_SYNC_ACQUIRED_4)
      next_good_cgs = 2'd0;
  end

  always_comb begin
    next_rx_even = ~rx_even;
    next_sync    = 1'b0;
    case (next_state)
      ST_COMMA_DETECT_1, ST_COMMA_DETECT_2, ST_COMMA_DETECT_3:
        next_rx_even = 1'b1;
      ST_SYNC_ACQUIRED_1, ST_SYNC_ACQUIRED_2, ST_SYNC_ACQUIRED_2A,
      ST_SYNC_ACQUIRED_3, ST_SYNC_ACQUIRED_3A, ST_SYNC_ACQUIRED_4,
      ST_SYNC_ACQUIRED_4A:
        next_sync = 1'b1;
      default: ;
    endcase
    sudi_d                           = '0;
    sudi_d[SUDI_CG_MSB:SUDI_CG_LSB]  = sif.PUDI;
    sudi_d[SUDI_EVEN_BIT]            = next_rx_even;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sudi_q <= '0;
      sync_q <= 1'b0;
    end else begin
      sudi_q <= sudi_d;
      sync_q <= next_sync;
    end
  end

  assign sif.SUDI        = sudi_q;
  assign sif.SYNC_STATUS = sync_q;

endmodule

// File: tb/tb_sincronizador.sv
// Self-checking bench for sincronizador: scoreboard of expected SUDI/SYNC_STATUS per code group.
// Latency: expectations checked #1 after the edge that registers each group. Backpressure: none.
module tb_sincronizador;
  import sincronizador_pkg::*;

  localparam logic [9:0] D5_6  = 10'b1010010110;
  localparam logic [9:0] D21_5 = 10'b1010101010;
  localparam logic [9:0] K27_7 = 10'b1101101000;
  localparam logic [9:0] ALL1  = 10'b1111111111;
  localparam int         LIMIT = 3;

  typedef struct packed {
    logic [10:0] sudi;
    logic        sync;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  sincronizador_if sif ();

  sincronizador #(.GOOD_CGS_LIMIT(LIMIT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .sif   (sif)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  logic [10:0] obs_sudi;
  logic        obs_sync;

  // Reference model: phase 0 = loss, 1/3/5 = comma detect, 2/4 = acquire, 6 = synced at level m_lvl.
  int   m_phase = 0;
  int   m_lvl   = 0;
  int   m_good  = 0;
  logic m_even  = 1'b0;

  task automatic model_step(input logic [9:0] p, input logic r);
    exp_t e;
    logic imb, cm, bad;
    if (r) begin
      m_phase = 0; m_lvl = 0; m_good = 0; m_even = 1'b0;
      e.sudi = '0; e.sync = 1'b0;
    end else begin
      imb = 1'b0;
`ifdef SINC_BALANCE_CHECK_EN
      imb = ($countones(p) < 4) || ($countones(p) > 6) ||
            ($countones(p[9:4]) < 2) || ($countones(p[9:4]) > 4) ||
            ($countones(p[3:0]) < 1) || ($countones(p[3:0]) > 3);
`endif
      cm  = (p == K28_5_P || p == K28_5_N) && !imb;
      bad = imb || (cm && m_even);
      case (m_phase)
        0: if (cm) m_phase = 1;
        1, 3, 5: begin
          if (!cm && !bad) begin
            m_phase = m_phase + 1;
            m_lvl = 1; m_good = 0;
          end else m_phase = 0;
        end
        2, 4: begin
          if (bad) m_phase = 0;
          else if (cm) m_phase = m_phase + 1;
        end
        default: begin
          if (bad) begin
            m_good = 0;
            if (m_lvl == 4) m_phase = 0;
            else m_lvl = m_lvl + 1;
          end else if (m_lvl > 1) begin
            m_good = m_good + 1;
            if (m_good == LIMIT) begin
              m_lvl = m_lvl - 1; m_good = 0;
            end
          end
        end
      endcase
      m_even = (m_phase == 1 || m_phase == 3 || m_phase == 5) ? 1'b1 : ~m_even;
      e.sudi = {p, m_even};
      e.sync = (m_phase == 6);
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [9:0] p, input logic r);
    @(negedge CLK);
    RESET    = r;
    sif.PUDI = p;
    model_step(p, r);
    @(posedge CLK);
    #1;
    obs_sudi = sif.SUDI;
    obs_sync = sif.SYNC_STATUS;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(10'($urandom), 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL reset[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
  endtask

  task automatic test_acquisition;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? K28_5_P : D5_6, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL acquire[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
    checks++;
    if (obs_sudi !== 11'b10100101100 || obs_sync !== 1'b1) begin
      errors++;
      $display("FAIL acquire_final: sudi=%b sync=%b want sudi=10100101100 sync=1", obs_sudi, obs_sync);
    end
  endtask

  task automatic test_misaligned_comma;
    exp_t e;
    logic [9:0] seq[$];
    logic       rst[$];
    seq = '{D5_6, K28_5_N, D5_6, D5_6, K28_5_P, D21_5, K28_5_P};
    rst = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], rst[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL misaligned[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
    checks++;
    if (obs_sudi !== {K28_5_P, 1'b1} || obs_sync !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_restart: sudi=%b sync=%b want comma in even slot, sync=0", obs_sudi, obs_sync);
    end
  endtask

  task automatic test_loss;
    exp_t e;
    logic [9:0] seq[$];
    drive(D5_6, 1'b1);
    void'(sb_q.pop_front());
    test_acquisition();
`ifdef SINC_BALANCE_CHECK_EN
    seq = '{ALL1, ALL1, ALL1, ALL1};
`else
    seq = '{D5_6, K28_5_P, D5_6, K28_5_P, D5_6, K28_5_P, D5_6, K28_5_P};
`endif
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL loss[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
    checks++;
    if (obs_sync !== 1'b0) begin
      errors++;
      $display("FAIL loss_final: sync=%b want 0", obs_sync);
    end
  endtask

  task automatic test_recovery;
    exp_t e;
    logic [9:0] seq[$];
    drive(D5_6, 1'b1);
    void'(sb_q.pop_front());
    test_acquisition();
    // Pad to odd parity, one misaligned comma, then three good groups.
    seq = '{D5_6, K28_5_P, D5_6, D21_5, D5_6};
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL recover[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
    checks++;
    if (obs_sync !== 1'b1) begin
      errors++;
      $display("FAIL recover_hold: sync=%b want 1", obs_sync);
    end
    seq = '{K28_5_P, D5_6, K28_5_N, D5_6, K28_5_P, D5_6, K28_5_N};
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL alternate[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
    end
    checks++;
    if (obs_sync !== 1'b0) begin
      errors++;
      $display("FAIL alternate_final: sync=%b want 0", obs_sync);
    end
  endtask

  task automatic test_midstream_reset;
    exp_t e;
    logic [9:0] seq[$];
    logic       rst[$];
    drive(D5_6, 1'b1);
    void'(sb_q.pop_front());
    test_acquisition();
    seq = '{K27_7, D21_5, D5_6, D21_5, D21_5,
            K28_5_P, D5_6, K28_5_N, D5_6, K28_5_P, D5_6};
    rst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], rst[i]);
      e = sb_q.pop_front();
      checks++;
      if (obs_sudi !== e.sudi || obs_sync !== e.sync) begin
        errors++;
        $display("FAIL midreset[%0d]: sudi=%b sync=%b want sudi=%b sync=%b", i, obs_sudi, obs_sync, e.sudi, e.sync);
      end
      if (i == 3) begin
        checks++;
        if (obs_sudi !== 11'd0 || obs_sync !== 1'b0) begin
          errors++;
          $display("FAIL midreset_zero: sudi=%b sync=%b want 0/0", obs_sudi, obs_sync);
        end
      end
    end
    checks++;
    if (obs_sync !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reacquire: sync=%b want 1", obs_sync);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    RESET    = 1'b1;
    sif.PUDI = '0;
    test_reset();
    test_acquisition();
    test_misaligned_comma();
    test_loss();
    test_recovery();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
